// File: rtl/rename_stall_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_stall_ctrl_if : decode->rename control bundle between front end and
//                        the rename stall controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface rename_stall_ctrl_if #(
    parameter int FL_CNT_W = 7,
    parameter int CKPT_W   = 3
);
    logic                flush_i;
    logic                bundle_valid_i;
    logic [2:0]          dest_cnt_i;
    logic [2:0]          branch_cnt_i;
    logic                backend_stall_i;
    logic [2:0]          commit_free_cnt_i;
    logic [2:0]          ckpt_release_cnt_i;
    logic [FL_CNT_W-1:0] flush_free_cnt_i;
    logic                stall_o;
    logic                fire_o;
    logic [FL_CNT_W-1:0] free_cnt_o;
    logic [CKPT_W-1:0]   ckpt_free_o;
    logic [3:0]          stall_cause_o;
    logic                overflow_o;

    modport master (
        output flush_i, bundle_valid_i, dest_cnt_i, branch_cnt_i, backend_stall_i,
               commit_free_cnt_i, ckpt_release_cnt_i, flush_free_cnt_i,
        input  stall_o, fire_o, free_cnt_o, ckpt_free_o, stall_cause_o, overflow_o
    );

    modport slave (
        input  flush_i, bundle_valid_i, dest_cnt_i, branch_cnt_i, backend_stall_i,
               commit_free_cnt_i, ckpt_release_cnt_i, flush_free_cnt_i,
        output stall_o, fire_o, free_cnt_o, ckpt_free_o, stall_cause_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/rename_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_stall_ctrl : stall/fire control for the decode->rename register with
//                     free-list / checkpoint accounting and flush recovery.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rename_stall_ctrl #(
    parameter int FREE_REGS      = 96,
    parameter int FL_CNT_W       = 7,
    parameter int BRANCH_CKPTS   = 4,
    parameter int CKPT_W         = 3,
    parameter int RECOVER_CYCLES = 2,
    parameter int RCV_W          = 2
) (
    input  wire                 clk,
    input  wire                 reset,
    rename_stall_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    localparam logic [FL_CNT_W:0] c_FREE_MAX = (FL_CNT_W+1)'(FREE_REGS);
    localparam logic [CKPT_W:0]   c_CKPT_MAX = (CKPT_W+1)'(BRANCH_CKPTS);

    state_t              r_state,    w_state_nxt;
    logic [FL_CNT_W-1:0] r_free_cnt, w_free_nxt;
    logic [CKPT_W-1:0]   r_ckpt,     w_ckpt_nxt;
    logic [RCV_W-1:0]    r_rcnt,     w_rcnt_nxt;
    logic                r_ovf,      w_ovf_nxt;

    logic                w_dest_short, w_ckpt_short, w_fire_ok, w_fire, w_stall;
    logic [3:0]          w_cause;
    logic [FL_CNT_W:0]   w_free_sum;
    logic [CKPT_W:0]     w_ckpt_sum;

    // Checks use registered counts only; same-cycle credits are not visible.
    always_comb begin
        w_dest_short = FL_CNT_W'(bus.dest_cnt_i) > r_free_cnt;
        w_ckpt_short = CKPT_W'(bus.branch_cnt_i) > r_ckpt;
        w_fire_ok    = (r_state == S_RUN) & bus.bundle_valid_i & ~bus.backend_stall_i
                       & ~w_dest_short & ~w_ckpt_short;
        w_fire       = w_fire_ok & ~bus.flush_i;
        w_stall      = (r_state == S_RECOVER) | (bus.bundle_valid_i & ~w_fire_ok);
        w_cause      = 4'b0000;
        if (r_state == S_RECOVER) begin
            w_cause = 4'b1000;
        end else if (w_stall) begin
            w_cause = {1'b0, w_ckpt_short, w_dest_short, bus.backend_stall_i};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_ovf_nxt   = r_ovf;
        w_free_sum  = (FL_CNT_W+1)'(r_free_cnt) + (FL_CNT_W+1)'(bus.commit_free_cnt_i)
                      - (w_fire ? (FL_CNT_W+1)'(bus.dest_cnt_i) : '0);
        w_ckpt_sum  = (CKPT_W+1)'(r_ckpt);
        if (r_state == S_RUN) begin
            w_ckpt_sum = (CKPT_W+1)'(r_ckpt) + (CKPT_W+1)'(bus.ckpt_release_cnt_i)
                         - (w_fire ? (CKPT_W+1)'(bus.branch_cnt_i) : '0);
        end
        if (bus.flush_i) begin
            w_free_sum  = {1'b0, bus.flush_free_cnt_i};
            w_ckpt_sum  = c_CKPT_MAX;
            w_state_nxt = S_RECOVER;
            w_rcnt_nxt  = RCV_W'(RECOVER_CYCLES - 1);
        end else if (r_state == S_RECOVER) begin
            if (r_rcnt == '0) begin
                w_state_nxt = S_RUN;
            end else begin
                w_rcnt_nxt = r_rcnt - 1'b1;
            end
        end
        w_free_nxt = w_free_sum[FL_CNT_W-1:0];
        if (w_free_sum > c_FREE_MAX) begin
            w_free_nxt = c_FREE_MAX[FL_CNT_W-1:0];
            w_ovf_nxt  = 1'b1;
        end
        w_ckpt_nxt = w_ckpt_sum[CKPT_W-1:0];
        if (w_ckpt_sum > c_CKPT_MAX) begin
            w_ckpt_nxt = c_CKPT_MAX[CKPT_W-1:0];
            w_ovf_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_free_cnt <= FL_CNT_W'(FREE_REGS);
            r_ckpt     <= CKPT_W'(BRANCH_CKPTS);
            r_rcnt     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_free_cnt <= w_free_nxt;
            r_ckpt     <= w_ckpt_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    assign bus.stall_o       = w_stall;
    assign bus.fire_o        = w_fire;
    assign bus.free_cnt_o    = r_free_cnt;
    assign bus.ckpt_free_o   = r_ckpt;
    assign bus.stall_cause_o = w_cause;
    assign bus.overflow_o    = r_ovf;
endmodule
`default_nettype wire
